// File: rtl/i2c_target_responder.sv
// rtl/i2c_target_responder.sv - I2C target turning bus writes into register-pointer/data strobes
// Read support (RDATA/RACK, rd_req) is compiled in only with `define I2C_TARGET_READ_EN.
module i2c_target_responder #(
   parameter logic [6:0] DEV_ADDR    = 7'h3C,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        ack_clk,
   input  logic        reset,
   input  logic        scl,
   inout  wire         sda,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        wr_strobe,
   output logic        rd_req,
   input  logic [7:0]  rd_data,
   output logic        busy
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ACK_ADDR, REG_HI, ACK_HI, REG_LO, ACK_LO,
      WDATA, ACK_WDATA, RDATA, RACK, IGNORE
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_prev_q, scl_prev_d;
   logic                   sda_prev_q, sda_prev_d;
   logic [3:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             shift_q, shift_d;
   logic                   sda_oe_q, sda_oe_d;
   logic                   busy_q, busy_d;
   logic [15:0]            wr_addr_q, wr_addr_d;
   logic [7:0]             wr_data_q, wr_data_d;
   logic                   wr_strobe_q, wr_strobe_d;

   logic       scl_s, sda_s;
   logic       scl_rise, scl_fall, start_det, stop_det;
   logic       byte_done, addr_ok;
   logic [7:0] rx_byte;

`ifdef I2C_TARGET_READ_EN
   logic       rd_mode_q, rd_mode_d;
   logic       mack_q, mack_d;
   logic [7:0] tx_q, tx_d;
   logic [1:0] rd_pipe_q, rd_pipe_d;
   logic       rd_req_q, rd_req_d;
`endif

   // Synchronizers and edge history; all bus decisions use only these outputs.
   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_prev_d = scl_s;
      sda_prev_d = sda_s;
   end

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;
   // Only the current scl level is required, so an sda edge coinciding with an scl rise still counts.
   assign start_det = scl_s & sda_prev_q & ~sda_s;
   assign stop_det  = scl_s & ~sda_prev_q & sda_s;
   assign byte_done = (bit_cnt_q == 4'd8);
   assign rx_byte   = {shift_q[6:0], sda_s};

`ifdef I2C_TARGET_READ_EN
   assign addr_ok = (shift_q[7:1] == DEV_ADDR);
`else
   assign addr_ok = (shift_q[7:1] == DEV_ADDR) && !shift_q[0];
`endif

   always_ff @(posedge ack_clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (stop_det) begin
         state_d = IDLE;
      end else if (start_det) begin
         state_d = ADDR;
      end else if (scl_fall) begin
         case (state_q)
            ADDR:      if (byte_done) state_d = addr_ok ? ACK_ADDR : IGNORE;
`ifdef I2C_TARGET_READ_EN
            ACK_ADDR:  state_d = rd_mode_q ? RDATA : REG_HI;
            RDATA:     if (byte_done) state_d = RACK;
            RACK:      state_d = mack_q ? RDATA : IGNORE;
`else
            ACK_ADDR:  state_d = REG_HI;
`endif
            REG_HI:    if (byte_done) state_d = ACK_HI;
            ACK_HI:    state_d = REG_LO;
            REG_LO:    if (byte_done) state_d = ACK_LO;
            ACK_LO:    state_d = WDATA;
            WDATA:     if (byte_done) state_d = ACK_WDATA;
            ACK_WDATA: state_d = WDATA;
            default:   state_d = state_q;
         endcase
      end
   end

   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      sda_oe_d    = sda_oe_q;
      busy_d      = busy_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      wr_strobe_d = 1'b0;
`ifdef I2C_TARGET_READ_EN
      rd_mode_d = rd_mode_q;
      mack_d    = mack_q;
      tx_d      = tx_q;
      rd_req_d  = 1'b0;
      rd_pipe_d = {rd_pipe_q[0], rd_req_q};
      if (rd_pipe_q[1]) tx_d = rd_data;
`endif
      if (stop_det) begin
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
         bit_cnt_d = 4'd0;
      end else if (start_det) begin
         sda_oe_d  = 1'b0;
         busy_d    = 1'b1;
         bit_cnt_d = 4'd0;
      end else if (scl_rise) begin
         case (state_q)
            ADDR, REG_HI, REG_LO, WDATA: begin
               if (!byte_done) begin
                  shift_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     if (state_q == REG_HI) wr_addr_d[15:8] = rx_byte;
                     if (state_q == REG_LO) wr_addr_d[7:0] = rx_byte;
                     if (state_q == WDATA) begin
                        wr_data_d   = rx_byte;
                        wr_strobe_d = 1'b1;
                     end
                  end
               end
            end
`ifdef I2C_TARGET_READ_EN
            RDATA: begin
               if (!byte_done) bit_cnt_d = bit_cnt_q + 4'd1;
            end
            // Fetch the next byte at the ACK rise so it is ready to drive on the following fall.
            RACK: begin
               mack_d = ~sda_s;
               if (!sda_s) begin
                  wr_addr_d = wr_addr_q + 16'd1;
                  rd_req_d  = 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end else if (scl_fall) begin
         case (state_q)
            ADDR: begin
               if (byte_done) begin
                  bit_cnt_d = 4'd0;
                  sda_oe_d  = addr_ok;
`ifdef I2C_TARGET_READ_EN
                  rd_mode_d = shift_q[0];
                  rd_req_d  = addr_ok & shift_q[0];
`endif
               end
            end
            REG_HI, REG_LO, WDATA: begin
               if (byte_done) begin
                  bit_cnt_d = 4'd0;
                  sda_oe_d  = 1'b1;
                  if (state_q == WDATA) wr_addr_d = wr_addr_q + 16'd1;
               end
            end
            ACK_ADDR: begin
               sda_oe_d = 1'b0;
`ifdef I2C_TARGET_READ_EN
               if (rd_mode_q) sda_oe_d = ~tx_q[7];
`endif
            end
            ACK_HI, ACK_LO, ACK_WDATA: sda_oe_d = 1'b0;
`ifdef I2C_TARGET_READ_EN
            RDATA: begin
               if (byte_done) begin
                  bit_cnt_d = 4'd0;
                  sda_oe_d  = 1'b0;
               end else begin
                  tx_d     = {tx_q[6:0], 1'b0};
                  sda_oe_d = ~tx_q[6];
               end
            end
            RACK: sda_oe_d = mack_q & ~tx_q[7];
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge ack_clk or posedge reset) begin
      if (reset) begin
         scl_sync_q  <= '1;
         sda_sync_q  <= '1;
         scl_prev_q  <= 1'b1;
         sda_prev_q  <= 1'b1;
         bit_cnt_q   <= 4'd0;
         shift_q     <= 8'd0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         wr_addr_q   <= 16'd0;
         wr_data_q   <= 8'd0;
         wr_strobe_q <= 1'b0;
      end else begin
         scl_sync_q  <= scl_sync_d;
         sda_sync_q  <= sda_sync_d;
         scl_prev_q  <= scl_prev_d;
         sda_prev_q  <= sda_prev_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         sda_oe_q    <= sda_oe_d;
         busy_q      <= busy_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         wr_strobe_q <= wr_strobe_d;
      end
   end

`ifdef I2C_TARGET_READ_EN
   always_ff @(posedge ack_clk or posedge reset) begin
      if (reset) begin
         rd_mode_q <= 1'b0;
         mack_q    <= 1'b0;
         tx_q      <= 8'hFF;
         rd_pipe_q <= 2'b00;
         rd_req_q  <= 1'b0;
      end else begin
         rd_mode_q <= rd_mode_d;
         mack_q    <= mack_d;
         tx_q      <= tx_d;
         rd_pipe_q <= rd_pipe_d;
         rd_req_q  <= rd_req_d;
      end
   end

   assign rd_req = rd_req_q;
`else
   logic unused_rd_data;
   assign unused_rd_data = ^rd_data;
   assign rd_req         = 1'b0;
`endif

   assign sda       = sda_oe_q ? 1'b0 : 1'bz;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign wr_strobe = wr_strobe_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_responder.sv
// tb/tb_i2c_target_responder.sv - scoreboard bench for i2c_target_responder
// Read checks follow `define I2C_TARGET_READ_EN.
module tb_i2c_target_responder;

   localparam int HALF = 20;

   logic        ack_clk = 1'b0;
   logic        reset   = 1'b1;
   logic        scl     = 1'b1;
   logic        tb_low  = 1'b0;
   logic [7:0]  rd_data = 8'h56;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        wr_strobe, rd_req, busy;
   wire         sda;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [23:0] wr_exp_q[$];
   logic [15:0] rd_exp_q[$];
   logic [23:0] wr_e;
   logic [15:0] rd_e;
   logic [7:0]  rx;

   pullup (sda);
   assign sda = tb_low ? 1'b0 : 1'bz;

   always #5 ack_clk = ~ack_clk;

   i2c_target_responder #(.DEV_ADDR(7'h3C), .SYNC_STAGES(2)) dut (
      .ack_clk   (ack_clk),
      .reset     (reset),
      .scl       (scl),
      .sda       (sda),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_strobe (wr_strobe),
      .rd_req    (rd_req),
      .rd_data   (rd_data),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every DUT strobe / read request is matched against the queued expectation.
   always @(negedge ack_clk) begin
      if (wr_strobe === 1'b1) begin
         if (wr_exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_wr_strobe: got addr=%h data=%h expected no strobe", wr_addr, wr_data);
         end else begin
            wr_e = wr_exp_q.pop_front();
            check("wr_strobe_addr_data", {8'h0, wr_addr, wr_data}, {8'h0, wr_e});
         end
      end
      if (rd_req === 1'b1) begin
         if (rd_exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rd_req: got addr=%h expected no rd_req", wr_addr);
         end else begin
            rd_e = rd_exp_q.pop_front();
            check("rd_req_addr", {16'h0, wr_addr}, {16'h0, rd_e});
         end
      end
   end

   task automatic clks(input int n);
      repeat (n) @(negedge ack_clk);
   endtask

   task automatic i2c_start();
      tb_low = 1'b0;
      clks(HALF);
      scl = 1'b1;
      clks(HALF);
      tb_low = 1'b1;
      clks(HALF);
      scl = 1'b0;
      clks(4);
   endtask

   task automatic i2c_stop();
      tb_low = 1'b1;
      clks(HALF);
      scl = 1'b1;
      clks(HALF);
      tb_low = 1'b0;
      clks(HALF);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         tb_low = ~b[i];
         clks(HALF);
         scl = 1'b1;
         clks(HALF);
         scl = 1'b0;
         clks(4);
      end
   endtask

   task automatic ack_slot(input string name, input logic exp_ack);
      tb_low = 1'b0;
      clks(HALF);
      scl = 1'b1;
      clks(HALF / 2);
      check(name, {31'b0, sda}, exp_ack ? 32'd0 : 32'd1);
      clks(HALF / 2);
      scl = 1'b0;
      clks(4);
   endtask

   task automatic send_byte(input string name, input logic [7:0] b, input logic exp_ack);
      send_bits(b, 8);
      ack_slot(name, exp_ack);
   endtask

   task automatic recv_byte(output logic [7:0] b, input logic nack);
      tb_low = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         clks(HALF);
         scl = 1'b1;
         clks(HALF / 2);
         b[i] = sda;
         clks(HALF / 2);
         scl = 1'b0;
         clks(4);
      end
      tb_low = ~nack;
      clks(HALF);
      scl = 1'b1;
      clks(HALF);
      scl = 1'b0;
      clks(4);
   endtask

   initial begin
      clks(5);
      reset = 1'b0;
      clks(3);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_wr_strobe", {31'b0, wr_strobe}, 32'd0);
      check("rst_rd_req", {31'b0, rd_req}, 32'd0);
      check("rst_wr_addr", {16'b0, wr_addr}, 32'd0);
      check("rst_wr_data", {24'b0, wr_data}, 32'd0);
      check("rst_sda", {31'b0, sda}, 32'd1);

      // Single write: pointer 0x3008, data 0x82
      i2c_start();
      check("busy_after_start", {31'b0, busy}, 32'd1);
      send_byte("w1_addr_ack", 8'h78, 1'b1);
      send_byte("w1_reghi_ack", 8'h30, 1'b1);
      send_byte("w1_reglo_ack", 8'h08, 1'b1);
      wr_exp_q.push_back({16'h3008, 8'h82});
      send_byte("w1_data_ack", 8'h82, 1'b1);
      i2c_stop();
      check("busy_after_stop", {31'b0, busy}, 32'd0);

      // Wrong address: no ACK, bus left alone, busy until STOP
      i2c_start();
      send_byte("bad_addr_nack", 8'h7A, 1'b0);
      send_byte("bad_next_nack", 8'h30, 1'b0);
      check("bad_busy_high", {31'b0, busy}, 32'd1);
      i2c_stop();
      check("bad_busy_low", {31'b0, busy}, 32'd0);

      // Burst write with pointer increment
      i2c_start();
      send_byte("w2_addr_ack", 8'h78, 1'b1);
      send_byte("w2_reghi_ack", 8'h30, 1'b1);
      send_byte("w2_reglo_ack", 8'h08, 1'b1);
      wr_exp_q.push_back({16'h3008, 8'h11});
      wr_exp_q.push_back({16'h3009, 8'h22});
      send_byte("w2_d0_ack", 8'h11, 1'b1);
      send_byte("w2_d1_ack", 8'h22, 1'b1);
      i2c_stop();

      // Pointer wrap 0xFFFF -> 0x0000
      i2c_start();
      send_byte("w3_addr_ack", 8'h78, 1'b1);
      send_byte("w3_reghi_ack", 8'hFF, 1'b1);
      send_byte("w3_reglo_ack", 8'hFF, 1'b1);
      wr_exp_q.push_back({16'hFFFF, 8'hAA});
      wr_exp_q.push_back({16'h0000, 8'hBB});
      send_byte("w3_d0_ack", 8'hAA, 1'b1);
      send_byte("w3_d1_ack", 8'hBB, 1'b1);
      i2c_stop();

      // STOP after half a data byte: no strobe
      i2c_start();
      send_byte("p_addr_ack", 8'h78, 1'b1);
      send_byte("p_reghi_ack", 8'h30, 1'b1);
      send_byte("p_reglo_ack", 8'h08, 1'b1);
      send_bits(8'hC5, 4);
      i2c_stop();
      check("partial_busy", {31'b0, busy}, 32'd0);
      check("partial_sda", {31'b0, sda}, 32'd1);

      // Reset while the target is driving ACK
      i2c_start();
      send_byte("r_addr_ack", 8'h78, 1'b1);
      send_bits(8'h12, 8);
      tb_low = 1'b0;
      clks(HALF / 2);
      check("r_ack_driven", {31'b0, sda}, 32'd0);
      reset = 1'b1;
      #1;
      check("r_sda_released", {31'b0, sda}, 32'd1);
      check("r_busy", {31'b0, busy}, 32'd0);
      check("r_wr_addr", {16'b0, wr_addr}, 32'd0);
      clks(4);
      reset = 1'b0;
      clks(4);
      send_byte("r_no_start_nack", 8'h78, 1'b0);
      check("r_no_start_busy", {31'b0, busy}, 32'd0);
      i2c_stop();
      i2c_start();
      send_byte("r2_addr_ack", 8'h78, 1'b1);
      send_byte("r2_reghi_ack", 8'h00, 1'b1);
      send_byte("r2_reglo_ack", 8'h05, 1'b1);
      wr_exp_q.push_back({16'h0005, 8'h99});
      send_byte("r2_data_ack", 8'h99, 1'b1);
      i2c_stop();

      // Read: pointer 0x300A, repeated START, 0x79
      i2c_start();
      send_byte("rd_waddr_ack", 8'h78, 1'b1);
      send_byte("rd_reghi_ack", 8'h30, 1'b1);
      send_byte("rd_reglo_ack", 8'h0A, 1'b1);
      i2c_start();
`ifdef I2C_TARGET_READ_EN
      rd_exp_q.push_back(16'h300A);
      send_byte("rd_raddr_ack", 8'h79, 1'b1);
      recv_byte(rx, 1'b1);
      check("rd_byte", {24'b0, rx}, 32'h56);
`else
      send_byte("rd_raddr_nack", 8'h79, 1'b0);
`endif
      i2c_stop();
      check("rd_end_sda", {31'b0, sda}, 32'd1);

      clks(20);
      check("wr_queue_drained", wr_exp_q.size(), 32'd0);
      check("rd_queue_drained", rd_exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
